// File: rtl/pong_round_ctrl_if.sv
// Game-sequencer port bundle: per-frame controls in, ball position, scores and status out.
interface pong_round_ctrl_if;
   logic       frame_tick;
   logic       start;
   logic       paddle_hit_x;
   logic       paddle_hit_y;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic [2:0] p1_score;
   logic [2:0] p2_score;
   logic [1:0] winner;
   logic [1:0] state;
   logic       game_over;

   modport master (
      output frame_tick, start, paddle_hit_x, paddle_hit_y,
      input  ball_x, ball_y, p1_score, p2_score, winner, state, game_over
   );

   modport slave (
      input  frame_tick, start, paddle_hit_x, paddle_hit_y,
      output ball_x, ball_y, p1_score, p2_score, winner, state, game_over
   );
endinterface

// File: rtl/pong_round_ctrl.sv
// Per-frame pong sequencer: ball motion, wall/paddle bounces, goals, scores, serve/hold/game-over.
// Optional macro PONG_SPEEDUP_EN: ball step grows (up to 4) every 4th paddle_hit_x within a rally.
module pong_round_ctrl #(
   parameter int WIDTH        = 640,
   parameter int HEIGHT       = 480,
   parameter int BALL_HW      = 10,
   parameter int BALL_HH      = 15,
   parameter int X_INIT       = 320,
   parameter int Y_INIT       = 240,
   parameter int SPEED        = 1,
   parameter int GOAL_TOP     = 200,
   parameter int GOAL_BOT     = 280,
   parameter int SERVE_FRAMES = 60,
   parameter int HOLD_FRAMES  = 90,
   parameter int WIN_SCORE    = 7
) (
   input  logic             clk,
   input  logic             reset,
   pong_round_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SERVE = 2'd1;
   localparam logic [1:0] S_PLAY  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam int CMAX = (SERVE_FRAMES > HOLD_FRAMES) ? SERVE_FRAMES : HOLD_FRAMES;
   localparam int CW   = $clog2(CMAX);

   localparam logic signed [10:0] X_LO = 11'(BALL_HW);
   localparam logic signed [10:0] X_HI = 11'(WIDTH - 1 - BALL_HW);
   localparam logic signed [9:0]  Y_LO = 10'(BALL_HH);
   localparam logic signed [9:0]  Y_HI = 10'(HEIGHT - 1 - BALL_HH);

   logic [1:0]    st;
   logic          over;
   logic [CW-1:0] cnt;
   logic [9:0]    bx;
   logic [8:0]    by;
   logic [2:0]    p1, p2;
   logic [1:0]    win;
   logic          dx_neg, dy_neg, srv_dx_neg, srv_dy_neg;
   logic [2:0]    step;
   logic          tick, win_reached, hold_done, enter_serve;

   assign tick        = bus.frame_tick;
   assign win_reached = (p1 >= 3'(WIN_SCORE)) || (p2 >= 3'(WIN_SCORE));
   assign hold_done   = (st == S_HOLD) && !over && tick && (cnt == CW'(HOLD_FRAMES - 1));
   // GAME_OVER lives inside S_HOLD, so over alone qualifies start there.
   assign enter_serve = (bus.start && ((st == S_IDLE) || over)) || (hold_done && !win_reached);

`ifdef PONG_SPEEDUP_EN
   logic [2:0] speed;
   logic [1:0] hit_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         speed   <= 3'(SPEED);
         hit_cnt <= 2'd0;
      end else if (enter_serve) begin
         speed   <= 3'(SPEED);
         hit_cnt <= 2'd0;
      end else if ((st == S_PLAY) && tick && bus.paddle_hit_x) begin
         hit_cnt <= hit_cnt + 2'd1;
         if ((hit_cnt == 2'd3) && (speed < 3'd4))
            speed <= speed + 3'd1;
      end
   end

   assign step = speed;
`else
   assign step = 3'(SPEED);
`endif

   // Next-position math, signed and one bit wider than the outputs so edge overshoot never wraps.
   logic               dxp, dyp, dx_new, dy_new, in_win, goal_p1, goal_p2;
   logic signed [10:0] nx;
   logic signed [9:0]  ny;
   logic [9:0]         x_new;
   logic [8:0]         y_new;

   always_comb begin
      dxp    = dx_neg ^ bus.paddle_hit_x;
      dyp    = dy_neg ^ bus.paddle_hit_y;
      ny     = dyp ? ($signed({1'b0, by}) - $signed({7'd0, step}))
                   : ($signed({1'b0, by}) + $signed({7'd0, step}));
      y_new  = ny[8:0];
      dy_new = dyp;
      if (ny <= Y_LO) begin
         y_new  = 9'(BALL_HH);
         dy_new = 1'b0;
      end else if (ny >= Y_HI) begin
         y_new  = 9'(HEIGHT - 1 - BALL_HH);
         dy_new = 1'b1;
      end
      in_win  = (y_new > 9'(GOAL_TOP)) && (y_new < 9'(GOAL_BOT));
      nx      = dxp ? ($signed({1'b0, bx}) - $signed({8'd0, step}))
                    : ($signed({1'b0, bx}) + $signed({8'd0, step}));
      x_new   = nx[9:0];
      dx_new  = dxp;
      goal_p1 = 1'b0;
      goal_p2 = 1'b0;
      if (nx <= X_LO) begin
         x_new   = 10'(BALL_HW);
         dx_new  = 1'b0;
         goal_p2 = in_win;
      end else if (nx >= X_HI) begin
         x_new   = 10'(WIDTH - 1 - BALL_HW);
         dx_new  = 1'b1;
         goal_p1 = in_win;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st         <= S_IDLE;
         over       <= 1'b0;
         cnt        <= '0;
         bx         <= 10'(X_INIT);
         by         <= 9'(Y_INIT);
         p1         <= 3'd0;
         p2         <= 3'd0;
         win        <= 2'd0;
         dx_neg     <= 1'b0;
         dy_neg     <= 1'b0;
         srv_dx_neg <= 1'b0;
         srv_dy_neg <= 1'b0;
      end else if (enter_serve) begin
         st  <= S_SERVE;
         cnt <= '0;
         bx  <= 10'(X_INIT);
         by  <= 9'(Y_INIT);
         if ((st == S_IDLE) || over) begin
            p1   <= 3'd0;
            p2   <= 3'd0;
            win  <= 2'd0;
            over <= 1'b0;
         end
      end else if (tick) begin
         case (st)
            S_SERVE: begin
               if (cnt == CW'(SERVE_FRAMES - 1)) begin
                  st         <= S_PLAY;
                  cnt        <= '0;
                  dx_neg     <= srv_dx_neg;
                  dy_neg     <= srv_dy_neg;
                  srv_dy_neg <= ~srv_dy_neg;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_PLAY: begin
               bx     <= x_new;
               by     <= y_new;
               dx_neg <= dx_new;
               dy_neg <= dy_new;
               if (goal_p1 || goal_p2) begin
                  // Next serve heads toward whoever just conceded.
                  srv_dx_neg <= goal_p2;
                  cnt        <= '0;
                  st         <= S_HOLD;
                  win        <= goal_p1 ? 2'd1 : 2'd2;
                  if (goal_p1 && (p1 != 3'd7)) p1 <= p1 + 3'd1;
                  if (goal_p2 && (p2 != 3'd7)) p2 <= p2 + 3'd1;
               end
            end
            S_HOLD: begin
               if (!over) begin
                  if (hold_done) over <= 1'b1;
                  else           cnt  <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ball_x    = bx;
   assign bus.ball_y    = by;
   assign bus.p1_score  = p1;
   assign bus.p2_score  = p2;
   assign bus.winner    = win;
   assign bus.state     = st;
   assign bus.game_over = over;
endmodule
